// File: rtl/mux_sel_arbiter.sv
// ============================================================================
//  Module   : mux_sel_arbiter
//  Brief    : N-way request arbiter (fixed priority or round-robin, burst cap)
//             driving a registered one-hot grant and binary mux select.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_sel_arbiter #(
    parameter int N_REQ     = 3,
    parameter int SEL_W     = 2,
    parameter int RR_EN     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [SEL_W-1:0] out_sel,
    output logic [N_REQ-1:0] gnt,
    output logic             proto_err
);

    localparam int c_CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_valid;
    logic [SEL_W-1:0]   r_sel;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_err;
    logic [c_CNT_W-1:0] r_beat_cnt;
    logic [SEL_W-1:0]   r_last_gnt;

    logic               w_pick_vld;
    logic [SEL_W-1:0]   w_pick_idx;
    logic [N_REQ-1:0]   w_pick_oh;
    logic               w_owner_req;
    logic               w_cap_hit;

    // Search starts just after the last owner in round-robin; fixed priority
    // starts after N_REQ-1, i.e. at index 0, so one loop serves both modes.
    always_comb begin : pick_logic
        int start;
        int idx;
        logic [N_REQ-1:0] probe;
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_pick_oh  = '0;
        start      = (RR_EN != 0) ? int'(r_last_gnt) : (N_REQ - 1);
        idx        = 0;
        probe      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx   = (start + k) % N_REQ;
            probe = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
            if (!w_pick_vld && ((req & probe) != '0)) begin
                w_pick_vld = 1'b1;
                w_pick_idx = SEL_W'(idx);
                w_pick_oh  = probe;
            end
        end
    end

    assign w_owner_req = |(req & r_gnt);
    assign w_cap_hit   = (r_beat_cnt == c_CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_sel      <= '0;
            r_gnt      <= '0;
            r_err      <= 1'b0;
            r_beat_cnt <= '0;
            r_last_gnt <= SEL_W'(N_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_state    <= BUSY;
                        r_valid    <= 1'b1;
                        r_sel      <= w_pick_idx;
                        r_gnt      <= w_pick_oh;
                        r_beat_cnt <= '0;
                        r_last_gnt <= w_pick_idx;
                    end
                end
                BUSY: begin
                    // Owner withdrew while its beat is stalled; the beat stays up.
                    if (!out_ready && !w_owner_req) begin
                        r_err <= 1'b1;
                    end
                    if (out_ready) begin
                        if (!w_owner_req || w_cap_hit) begin
                            if (w_pick_vld) begin
                                r_sel      <= w_pick_idx;
                                r_gnt      <= w_pick_oh;
                                r_beat_cnt <= '0;
                                r_last_gnt <= w_pick_idx;
                            end else begin
                                r_state    <= IDLE;
                                r_valid    <= 1'b0;
                                r_gnt      <= '0;
                                r_beat_cnt <= '0;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_sel   = r_sel;
    assign gnt       = r_gnt;
    assign proto_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
// ============================================================================
//  Module   : tb_mux_sel_arbiter
//  Brief    : Self-checking bench: three arbiter configurations against a
//             behavioural owner/beat model, directed scenarios then random.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_sel_arbiter;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       out_ready;

    logic       vld  [3];
    logic [1:0] sel  [3];
    logic [2:0] gnt  [3];
    logic       perr [3];

    int n_checks = 0;
    int n_errors = 0;

    // Instance 0: RR cap 4, instance 1: fixed cap 4, instance 2: RR cap 1
    int cfg_rr [3] = '{1, 0, 1};
    int cfg_mb [3] = '{4, 4, 1};

    // Model: owner index (-1 idle), beats completed in current grant
    int m_owner [3];
    int m_sel   [3];
    int m_err   [3];
    int m_beats [3];
    int m_last  [3];

    always #5 clk = ~clk;

    mux_sel_arbiter #(.N_REQ(3), .SEL_W(2), .RR_EN(1), .MAX_BURST(4)) u_rr4 (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .out_valid(vld[0]), .out_sel(sel[0]), .gnt(gnt[0]), .proto_err(perr[0]));

    mux_sel_arbiter #(.N_REQ(3), .SEL_W(2), .RR_EN(0), .MAX_BURST(4)) u_fix4 (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .out_valid(vld[1]), .out_sel(sel[1]), .gnt(gnt[1]), .proto_err(perr[1]));

    mux_sel_arbiter #(.N_REQ(3), .SEL_W(2), .RR_EN(1), .MAX_BURST(1)) u_rr1 (
        .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
        .out_valid(vld[2]), .out_sel(sel[2]), .gnt(gnt[2]), .proto_err(perr[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int rr, input int last);
        int start;
        int i;
        start = (rr != 0) ? (last + 1) % N : 0;
        for (int k = 0; k < N; k++) begin
            i = (start + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic r_rst, input logic [2:0] r, input logic rdy);
        int p;
        for (int m = 0; m < 3; m++) begin
            if (r_rst) begin
                m_owner[m] = -1;
                m_sel[m]   = 0;
                m_err[m]   = 0;
                m_beats[m] = 0;
                m_last[m]  = N - 1;
            end else if (m_owner[m] < 0) begin
                p = pick(r, cfg_rr[m], m_last[m]);
                if (p >= 0) begin
                    m_owner[m] = p; m_sel[m] = p; m_last[m] = p; m_beats[m] = 0;
                end
            end else if (!rdy) begin
                if (!r[m_owner[m]]) m_err[m] = 1;
            end else begin
                m_beats[m]++;
                if (!r[m_owner[m]] || m_beats[m] == cfg_mb[m]) begin
                    p = pick(r, cfg_rr[m], m_last[m]);
                    m_beats[m] = 0;
                    if (p >= 0) begin
                        m_owner[m] = p; m_sel[m] = p; m_last[m] = p;
                    end else begin
                        m_owner[m] = -1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r_rst, input logic [2:0] r, input logic rdy);
        logic [31:0] obs;
        logic [31:0] exp;
        logic [2:0]  eg;
        logic        ev;
        rst       = r_rst;
        req       = r;
        out_ready = rdy;
        @(posedge clk);
        model_edge(r_rst, r, rdy);
        #1;
        for (int m = 0; m < 3; m++) begin
            ev  = (m_owner[m] >= 0);
            eg  = ev ? (3'b001 << m_owner[m]) : 3'b000;
            exp = {25'd0, m_err[m] != 0, eg, 2'(m_sel[m]), ev};
            obs = {25'd0, perr[m], gnt[m], sel[m], vld[m]};
            chk($sformatf("model_inst%0d {err,gnt,sel,valid}", m), obs, exp);
        end
    endtask

    initial begin
        logic [2:0] rq;
        logic       rd;
        rst = 1'b1; req = '0; out_ready = 1'b0;

        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        chk("reset_valid", 32'(vld[0]), 32'd0);
        chk("reset_gnt", 32'(gnt[0]), 32'd0);

        // First RR pick after reset with 110 lands on index 1
        step(1'b0, 3'b110, 1'b1);
        chk("t1_sel", 32'(sel[0]), 32'd1);
        chk("t1_gnt", 32'(gnt[0]), 32'h2);

        // All request held: fixed stays on 0, RR cap1 rotates, RR cap4 bursts
        step(1'b1, 3'b000, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 3'b111, 1'b1);
            chk($sformatf("t2_fix_gnt_%0d", k), 32'(gnt[1]), 32'h1);
            chk($sformatf("t3_rr1_sel_%0d", k), 32'(sel[2]), 32'(k % 3));
            chk($sformatf("t3_rr1_valid_%0d", k), 32'(vld[2]), 32'd1);
            chk($sformatf("t_rr4_sel_%0d", k), 32'(sel[0]), 32'((k / 4) % 3));
        end

        // 101: four beats on 0, four beats on 2, no gap
        step(1'b1, 3'b000, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 3'b101, 1'b1);
            chk($sformatf("t4_sel_%0d", k), 32'(sel[0]), ((k / 4) % 2 != 0) ? 32'd2 : 32'd0);
            chk($sformatf("t4_valid_%0d", k), 32'(vld[0]), 32'd1);
        end

        // Stall, then owner withdraws while stalled
        step(1'b1, 3'b000, 1'b0);
        step(1'b0, 3'b010, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'b010, 1'b0);
            chk($sformatf("t5_stall_sel_%0d", k), 32'(sel[0]), 32'd1);
            chk($sformatf("t5_stall_valid_%0d", k), 32'(vld[0]), 32'd1);
        end
        step(1'b0, 3'b000, 1'b0);
        chk("t5_proto_err", 32'(perr[0]), 32'd1);
        chk("t5_hold_valid", 32'(vld[0]), 32'd1);
        step(1'b0, 3'b000, 1'b1);
        chk("t5_idle_valid", 32'(vld[0]), 32'd0);
        chk("t5_idle_sel_hold", 32'(sel[0]), 32'd1);
        step(1'b0, 3'b000, 1'b1);
        chk("t5_err_sticky", 32'(perr[0]), 32'd1);

        // Reset mid-burst on owner 2
        step(1'b1, 3'b000, 1'b1);
        step(1'b0, 3'b100, 1'b1);
        chk("t6_sel2", 32'(sel[0]), 32'd2);
        step(1'b0, 3'b100, 1'b1);
        step(1'b1, 3'b100, 1'b1);
        chk("t6_rst_valid", 32'(vld[0]), 32'd0);
        chk("t6_rst_gnt", 32'(gnt[0]), 32'd0);
        chk("t6_rst_err", 32'(perr[0]), 32'd0);
        step(1'b0, 3'b111, 1'b1);
        chk("t6_sel0", 32'(sel[0]), 32'd0);

        // Random traffic with occasional reset
        rq = 3'b000;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) < 3) rq = 3'($urandom_range(0, 7));
            rd = ($urandom_range(0, 9) < 7);
            step($urandom_range(0, 99) == 0, rq, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
